// File: rtl/blake2s_pkg.sv
// Shared constants, state encoding and job validation for the BLAKE2s block sequencer.
package blake2s_pkg;

    localparam int unsigned BLOCK_BYTES = 64;
    localparam int unsigned KK_MAX      = 32;
    localparam int unsigned NN_MAX      = 32;
    localparam logic [5:0]  IDX_LAST    = 6'(BLOCK_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        KEY      = 3'd1,
        KEY_PAD  = 3'd2,
        MSG      = 3'd3,
        MSG_PAD  = 3'd4,
        WAIT_BLK = 3'd5
    } blake2s_seq_state_t;

    // A job is legal when the digest length is 1..32 and the key length is at most 32.
    function automatic logic job_ok(input logic [5:0] kk, input logic [5:0] nn);
        return (nn != 6'd0) && (nn <= 6'(NN_MAX)) && (kk <= 6'(KK_MAX));
    endfunction

endpackage

// File: rtl/blake2s_len_cnt.sv
// Loadable down-counter tracking message bytes still to be sent to the core.
module blake2s_len_cnt
    import blake2s_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         le64_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load wins over decrement; the counter never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign le64_o  = (cnt_q <= W'(BLOCK_BYTES));
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/blake2s_block_seq.sv
// Turns one BLAKE2s job (kk, nn, ll plus a byte stream) into indexed 64-byte blocks for the core.
module blake2s_block_seq
    import blake2s_pkg::*;
#(
    parameter int LL_W = 64
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            start_i,
    input  logic [5:0]      kk_i,
    input  logic [5:0]      nn_i,
    input  logic [LL_W-1:0] ll_i,
    input  logic            byte_v_i,
    input  logic [7:0]      byte_i,
    output logic            byte_ready_o,
    input  logic            core_blk_done_i,
    output logic [5:0]      kk_o,
    output logic [5:0]      nn_o,
    output logic [LL_W-1:0] ll_o,
    output logic            data_v_o,
    output logic [7:0]      data_o,
    output logic [5:0]      data_idx_o,
    output logic            block_first_o,
    output logic            block_last_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    blake2s_seq_state_t state_q, state_d;

    logic [5:0]      kk_q, nn_q, idx_q, data_idx_q;
    logic [LL_W-1:0] ll_q, rem_cnt;
    logic [7:0]      data_q, emit_byte;
    logic            data_v_q, first_q, last_q, busy_q, done_q, err_q;
    logic            byte_ready, emit, start_ok, start_bad, blk_end, rem_dec;
    logic            rem_le64, rem_zero;

    blake2s_len_cnt #(.W(LL_W)) u_rem (
        .clk        (clk),
        .nreset     (nreset),
        .load_i     (start_ok),
        .load_val_i (ll_i),
        .dec_i      (rem_dec),
        .count_o    (rem_cnt),
        .le64_o     (rem_le64),
        .zero_o     (rem_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a block always runs through idx 63 before waiting for the core.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    if (kk_i != 6'd0)        state_d = KEY;
                    else if (ll_i != '0)     state_d = MSG;
                    else                     state_d = MSG_PAD;
                end
            end
            KEY: begin
                if (emit && (idx_q == kk_q - 6'd1)) state_d = KEY_PAD;
            end
            KEY_PAD, MSG_PAD: begin
                if (idx_q == IDX_LAST) state_d = WAIT_BLK;
            end
            MSG: begin
                if (emit) begin
                    if (idx_q == IDX_LAST)          state_d = WAIT_BLK;
                    else if (rem_cnt == LL_W'(1))   state_d = MSG_PAD;
                end
            end
            WAIT_BLK: begin
                if (blk_end) state_d = last_q ? IDLE : MSG;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-state strobes: source handshake, byte emission and job/block events.
    always_comb begin
        byte_ready = 1'b0;
        emit       = 1'b0;
        emit_byte  = 8'h00;
        start_ok   = 1'b0;
        start_bad  = 1'b0;
        blk_end    = 1'b0;
        rem_dec    = 1'b0;
        case (state_q)
            IDLE: begin
                start_ok  = start_i &  job_ok(kk_i, nn_i);
                start_bad = start_i & ~job_ok(kk_i, nn_i);
            end
            KEY: begin
                byte_ready = 1'b1;
                emit       = byte_v_i;
                emit_byte  = byte_i;
            end
            MSG: begin
                // Never pull bytes beyond ll, even transiently.
                byte_ready = ~rem_zero;
                emit       = byte_v_i & ~rem_zero;
                emit_byte  = byte_i;
                rem_dec    = byte_v_i & ~rem_zero;
            end
            KEY_PAD, MSG_PAD: emit = 1'b1;
            WAIT_BLK: blk_end = core_blk_done_i;
            default: ;
        endcase
    end

    // Registered block-byte outputs, job parameters and block flags.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            kk_q       <= '0;
            nn_q       <= '0;
            ll_q       <= '0;
            idx_q      <= '0;
            data_idx_q <= '0;
            data_q     <= '0;
            data_v_q   <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            data_v_q <= emit;
            err_q    <= start_bad;
            done_q   <= blk_end & last_q;
            if (emit) begin
                data_q     <= emit_byte;
                data_idx_q <= idx_q;
                idx_q      <= idx_q + 6'd1;  // wraps to 0 after idx 63
            end
            if (start_ok) begin
                kk_q    <= kk_i;
                nn_q    <= nn_i;
                ll_q    <= ll_i;
                busy_q  <= 1'b1;
                idx_q   <= '0;
                first_q <= 1'b1;
                // Key block is last only with an empty message; otherwise the first
                // message block (or the lone zero block when ll==0) decides.
                last_q  <= (kk_i != 6'd0) ? (ll_i == '0) : (ll_i <= LL_W'(BLOCK_BYTES));
            end
            if (blk_end) begin
                if (last_q) begin
                    busy_q <= 1'b0;
                end else begin
                    first_q <= 1'b0;
                    last_q  <= rem_le64;
                end
            end
        end
    end

    assign byte_ready_o  = byte_ready;
    assign kk_o          = kk_q;
    assign nn_o          = nn_q;
    assign ll_o          = ll_q;
    assign data_v_o      = data_v_q;
    assign data_o        = data_q;
    assign data_idx_o    = data_idx_q;
    assign block_first_o = first_q;
    assign block_last_o  = last_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule
